bfly_operand_loader: RTL and testbench

- Parametrised successor to the butterfly input register stage: assembles one radix-2 butterfly operand set (twiddle index W, B real/imag, A real/imag) from a serial word stream.
- An internal word sequencer replaces the external per-field flags.
- valid/ready handshakes on both sides, plus one shadow set of buffering, so the stream keeps loading while the butterfly stalls.
- Sits between the sample input port and the butterfly datapath.

---
 rtl/bfly_operand_loader_if.sv | 31 +++
 rtl/bfly_operand_loader.sv | 146 ++++++++++++++
 tb/tb_bfly_operand_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bfly_operand_loader_if.sv
// Handshake and operand bus for the butterfly operand loader.
// master drives the word stream and consumes sets; slave is the loader.
interface bfly_operand_loader_if #(
  parameter int DW = 8,
  parameter int WW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic          sop;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] w;
  logic [DW-1:0] reb;
  logic [DW-1:0] imb;
  logic [DW-1:0] rea;
  logic [DW-1:0] ima;
  logic          busy;
  logic          err;
  logic          clr_err;

  modport master (
    output in_valid, sop, din, out_ready, clr_err,
    input  in_ready, out_valid, w, reb, imb, rea, ima, busy, err
  );

  modport slave (
    input  in_valid, sop, din, out_ready, clr_err,
    output in_ready, out_valid, w, reb, imb, rea, ima, busy, err
  );
endinterface

// File: rtl/bfly_operand_loader.sv
// Serial-to-parallel butterfly operand loader with one shadow set.
// Optional protocol checks enabled by defining BFLY_LOAD_CHK_EN.
module bfly_operand_loader #(
  parameter int DW = 8,
  parameter int WW = 3
) (
  input  logic                  clock,
  input  logic                  rst,
  bfly_operand_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_W, S_REB, S_IMB, S_REA, S_IMA
  } state_e;

  state_e        state_q;
  logic          pend_q;
  logic          ov_q;
  logic [WW-1:0] ws_q;
  logic [DW-1:0] rebs_q;
  logic [DW-1:0] imbs_q;
  logic [DW-1:0] reas_q;
  logic [DW-1:0] imas_q;
  logic [WW-1:0] w_q;
  logic [DW-1:0] reb_q;
  logic [DW-1:0] imb_q;
  logic [DW-1:0] rea_q;
  logic [DW-1:0] ima_q;

  logic acc;
  logic consume;
  logic slot_free;

  assign acc       = bus.in_valid && !pend_q;
  assign consume   = ov_q && bus.out_ready;
  assign slot_free = !ov_q || bus.out_ready;

  // Sequencer, shadow capture, pend buffering and output register load
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_W;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      ws_q    <= '0;
      rebs_q  <= '0;
      imbs_q  <= '0;
      reas_q  <= '0;
      imas_q  <= '0;
      w_q     <= '0;
      reb_q   <= '0;
      imb_q   <= '0;
      rea_q   <= '0;
      ima_q   <= '0;
    end else begin
      if (consume) ov_q <= 1'b0;
      if (pend_q && consume) begin
        w_q    <= ws_q;
        reb_q  <= rebs_q;
        imb_q  <= imbs_q;
        rea_q  <= reas_q;
        ima_q  <= imas_q;
        ov_q   <= 1'b1;
        pend_q <= 1'b0;
      end
      if (acc) begin
        if (bus.sop) begin
          ws_q    <= bus.din[WW-1:0];
          state_q <= S_REB;
        end else begin
          unique case (state_q)
            S_W: begin
              ws_q    <= bus.din[WW-1:0];
              state_q <= S_REB;
            end
            S_REB: begin
              rebs_q  <= bus.din;
              state_q <= S_IMB;
            end
            S_IMB: begin
              imbs_q  <= bus.din;
              state_q <= S_REA;
            end
            S_REA: begin
              reas_q  <= bus.din;
              state_q <= S_IMA;
            end
            S_IMA: begin
              state_q <= S_W;
              if (slot_free) begin
                w_q   <= ws_q;
                reb_q <= rebs_q;
                imb_q <= imbs_q;
                rea_q <= reas_q;
                ima_q <= bus.din;
                ov_q  <= 1'b1;
              end else begin
                imas_q <= bus.din;
                pend_q <= 1'b1;
              end
            end
            default: state_q <= S_W;
          endcase
        end
      end
    end
  end

  assign bus.in_ready  = !pend_q;
  assign bus.out_valid = ov_q;
  assign bus.w         = w_q;
  assign bus.reb       = reb_q;
  assign bus.imb       = imb_q;
  assign bus.rea       = rea_q;
  assign bus.ima       = ima_q;
  assign bus.busy      = (state_q != S_W) || pend_q;

`ifdef BFLY_LOAD_CHK_EN
  logic err_q;
  logic rng_bad;
  logic set_err;

  if (WW < DW) begin : g_rng
    assign rng_bad = |bus.din[DW-1:WW];
  end else begin : g_norng
    assign rng_bad = 1'b0;
  end

  assign set_err = acc && (
    (bus.sop && state_q != S_W) ||
    ((bus.sop || state_q == S_W) && rng_bad));

  // Sticky error; a new event beats a simultaneous clear
  always_ff @(posedge clock or posedge rst) begin
    if (rst)              err_q <= 1'b0;
    else if (set_err)     err_q <= 1'b1;
    else if (bus.clr_err) err_q <= 1'b0;
  end

  assign bus.err = err_q;
`else
  logic unused_chk;
  assign unused_chk = bus.clr_err;
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_bfly_operand_loader.sv
// Directed bench for bfly_operand_loader (DW=8, WW=3).
// Expected err depends on BFLY_LOAD_CHK_EN.
module tb_bfly_operand_loader;

  logic clock;
  logic rst;
  int   errors;
  int   checks;

  bfly_operand_loader_if #(.DW(8), .WW(3)) bus ();

  bfly_operand_loader #(.DW(8), .WW(3)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef BFLY_LOAD_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic s, input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.sop      = s;
    bus.din      = d;
    while (!bus.in_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout: got in_ready=0 want 1");
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.sop      = 1'b0;
  endtask

  task automatic chk_set(input string tag, input logic [2:0] ew,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    chk({tag, "_w"},   bus.w,   ew);
    chk({tag, "_reb"}, bus.reb, a);
    chk({tag, "_imb"}, bus.imb, b);
    chk({tag, "_rea"}, bus.rea, c);
    chk({tag, "_ima"}, bus.ima, d);
  endtask

  logic [7:0] tbl [15];
  logic [2:0] wexp;

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sop       = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;

    // reset state
    chk("rst_ov",    bus.out_valid, 0);
    chk("rst_ready", bus.in_ready,  1);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_err",   bus.err,       0);
    chk_set("rst", 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);

    // 1: basic set
    bus.out_ready = 1'b1;
    beat(0, 8'h05);
    chk("t1_busy_mid", bus.busy, 1);
    beat(0, 8'h11); beat(0, 8'h22); beat(0, 8'h33); beat(0, 8'h44);
    chk("t1_ov", bus.out_valid, 1);
    chk_set("t1", 3'd5, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_busy", bus.busy, 0);
    @(posedge clock); #1;
    chk("t1_ov_fall", bus.out_valid, 0);

    // 2: stall with shadow set
    bus.out_ready = 1'b0;
    beat(0, 8'h01); beat(0, 8'h10); beat(0, 8'h20);
    beat(0, 8'h30); beat(0, 8'h40);
    chk("t2_ov_a", bus.out_valid, 1);
    beat(0, 8'h02); beat(0, 8'h50); beat(0, 8'h60);
    beat(0, 8'h70); beat(0, 8'h80);
    chk("t2_ready_pend", bus.in_ready, 0);
    chk("t2_busy_pend",  bus.busy,     1);
    chk_set("t2_hold_a", 3'd1, 8'h10, 8'h20, 8'h30, 8'h40);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("t2_ov_b",    bus.out_valid, 1);
    chk("t2_ready_b", bus.in_ready,  1);
    chk_set("t2_b", 3'd2, 8'h50, 8'h60, 8'h70, 8'h80);
    @(posedge clock); #1;
    chk("t2_hold_ov", bus.out_valid, 1);
    chk("t2_hold_w",  bus.w,         2);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk("t2_ov_drain", bus.out_valid, 0);

    // 3: truncated set restarted by sop
    beat(0, 8'h01); beat(0, 8'hAA);
    beat(1, 8'h02);
    beat(0, 8'h10); beat(0, 8'h20); beat(0, 8'h30); beat(0, 8'h40);
    chk("t3_ov", bus.out_valid, 1);
    chk_set("t3", 3'd2, 8'h10, 8'h20, 8'h30, 8'h40);
    chk("t3_err", bus.err, ERR_EXP);
    bus.clr_err = 1'b1;
    @(posedge clock); #1;
    bus.clr_err = 1'b0;
    chk("t3_err_clr", bus.err, 0);

    // 4: out-of-range twiddle index
    beat(0, 8'h0D); beat(0, 8'h01); beat(0, 8'h02);
    beat(0, 8'h03); beat(0, 8'h04);
    chk("t4_ov", bus.out_valid, 1);
    chk_set("t4", 3'd5, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("t4_err", bus.err, ERR_EXP);

    // 5: reset mid-set
    beat(0, 8'h03); beat(0, 8'h99); beat(0, 8'h98);
    rst = 1'b1;
    #1;
    chk("t5_ov",    bus.out_valid, 0);
    chk("t5_busy",  bus.busy,      0);
    chk("t5_err",   bus.err,       0);
    chk_set("t5_rst", 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clock); #1;
    rst = 1'b0;
    chk("t5_ready", bus.in_ready, 1);
    beat(0, 8'h07); beat(0, 8'hF0); beat(0, 8'h0F);
    beat(0, 8'h80); beat(0, 8'h7F);
    chk("t5_ov_set", bus.out_valid, 1);
    chk_set("t5", 3'd7, 8'hF0, 8'h0F, 8'h80, 8'h7F);
    @(posedge clock); #1;

    // 6: three sets back to back
    tbl = '{8'h03, 8'h11, 8'h12, 8'h13, 8'h14,
            8'h06, 8'h21, 8'h22, 8'h23, 8'h24,
            8'h00, 8'h31, 8'h32, 8'h33, 8'h34};
    for (int i = 0; i < 15; i++) begin
      chk("t6_ready", bus.in_ready, 1);
      beat(0, tbl[i]);
      if (i % 5 == 4) begin
        wexp = tbl[i-4][2:0];
        chk("t6_ov", bus.out_valid, 1);
        chk_set("t6", wexp, tbl[i-3], tbl[i-2], tbl[i-1], tbl[i]);
      end else if (i >= 5 && i % 5 == 0) begin
        chk("t6_ov_gap", bus.out_valid, 0);
      end
    end
    @(posedge clock); #1;
    chk("t6_ov_end", bus.out_valid, 0);
    chk("t6_busy",   bus.busy,      0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
